// File: rtl/assoc_cache.sv
`default_nettype none
// =============================================================================
// Module   : assoc_cache
// Purpose  : N-way set-associative data cache with a miss FSM and a block port.
//            ASSOC_CACHE_WB_EN selects write-back/write-allocate; without it the
//            cache is write-through/no-write-allocate.
// Revision : 1.0 - initial release
// =============================================================================
module assoc_cache #(
  parameter int SETS = 32,
  parameter int WAYS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addr,
  input  logic         re,
  input  logic         we,
  input  logic [31:0]  din,
  output logic [31:0]  dout,
  output logic         complete,
  output logic         mem_re,
  output logic         mem_we,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  output logic [3:0]   mem_wmask,
  input  logic [127:0] mem_rdata,
  input  logic         mem_complete
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = 30 - 2 - IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_WT   = 2'd3;

  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_bits;
  assign off = addr[3:2];
  assign idx = addr[4+IDX_W-1:4];
  assign tag = addr[31:4+IDX_W];
  assign unused_addr_bits = ^addr[1:0];

  logic             valid_q [WAYS][SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [127:0]     data_q  [WAYS][SETS];
  logic [WAY_W-1:0] rr_q    [SETS];
`ifdef ASSOC_CACHE_WB_EN
  logic             dirty_q [WAYS][SETS];
  logic             clr_dirty;
`else
  logic             wt_done_q, wt_done_d;
`endif

  logic [1:0]       state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [27:0]      blk_q, blk_d;
  logic             mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [27:0]      mem_addr_q, mem_addr_d;
  logic [127:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wmask_q, mem_wmask_d;

  logic             hit, has_inv, fill_we, word_we;
  logic [WAY_W-1:0] hit_way, inv_way, victim;
  logic [127:0]     hit_line;
  logic [IDX_W-1:0] fidx;
  logic [TAG_W-1:0] ftag;

  // Downward scan so the lowest-index invalid way wins the victim choice.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][idx]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim   = has_inv ? inv_way : rr_q[idx];
  assign hit_line = data_q[hit_way][idx];
  assign dout     = hit ? hit_line[{off, 5'd0} +: 32] : 32'd0;
  // The miss address is latched, so a withdrawn request still installs correctly.
  assign fidx     = blk_q[IDX_W-1:0];
  assign ftag     = blk_q[27:IDX_W];

  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    blk_d       = blk_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    complete    = 1'b0;
    fill_we     = 1'b0;
    word_we     = 1'b0;
`ifdef ASSOC_CACHE_WB_EN
    clr_dirty   = 1'b0;
`else
    wt_done_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!re && !we) begin
          complete = 1'b1;
`ifdef ASSOC_CACHE_WB_EN
        end else if (hit) begin
          complete = 1'b1;
          word_we  = we;
        end else begin
          victim_d = victim;
          blk_d    = addr[31:4];
          if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
            state_d     = S_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[victim][idx], idx};
            mem_wdata_d = data_q[victim][idx];
            mem_wmask_d = 4'b1111;
          end else begin
            state_d    = S_FILL;
            mem_re_d   = 1'b1;
            mem_addr_d = addr[31:4];
          end
        end
`else
        end else if (we) begin
          // A write finishes in the IDLE cycle right after its WT round trip.
          if (wt_done_q) begin
            complete = 1'b1;
          end else begin
            word_we     = hit;
            state_d     = S_WT;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr[31:4];
            mem_wdata_d = {4{din}};
            mem_wmask_d = 4'b0001 << off;
          end
        end else if (hit) begin
          complete = 1'b1;
        end else begin
          victim_d   = victim;
          blk_d      = addr[31:4];
          state_d    = S_FILL;
          mem_re_d   = 1'b1;
          mem_addr_d = addr[31:4];
        end
`endif
      end
`ifdef ASSOC_CACHE_WB_EN
      S_WB: begin
        if (mem_complete) begin
          clr_dirty  = 1'b1;
          state_d    = S_FILL;
          mem_we_d   = 1'b0;
          mem_re_d   = 1'b1;
          mem_addr_d = blk_q;
        end
      end
`endif
      S_FILL: begin
        if (mem_complete) begin
          fill_we  = 1'b1;
          state_d  = S_IDLE;
          mem_re_d = 1'b0;
        end
      end
`ifndef ASSOC_CACHE_WB_EN
      S_WT: begin
        if (mem_complete) begin
          state_d   = S_IDLE;
          mem_we_d  = 1'b0;
          wt_done_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      victim_q    <= '0;
      blk_q       <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
`ifndef ASSOC_CACHE_WB_EN
      wt_done_q   <= 1'b0;
`endif
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
`ifdef ASSOC_CACHE_WB_EN
          dirty_q[w][s] <= 1'b0;
`endif
        end
      end
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      blk_q       <= blk_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
`ifndef ASSOC_CACHE_WB_EN
      wt_done_q   <= wt_done_d;
`endif
      if (fill_we) begin
        valid_q[victim_q][fidx] <= 1'b1;
        rr_q[fidx] <= (rr_q[fidx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[fidx] + 1'b1;
`ifdef ASSOC_CACHE_WB_EN
        dirty_q[victim_q][fidx] <= 1'b0;
`endif
      end
`ifdef ASSOC_CACHE_WB_EN
      if (clr_dirty) dirty_q[victim_q][fidx] <= 1'b0;
      if (word_we)   dirty_q[hit_way][idx]   <= 1'b1;
`endif
    end
  end

  // Payload arrays need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[victim_q][fidx] <= mem_rdata;
      tag_q[victim_q][fidx]  <= ftag;
    end
    if (word_we) data_q[hit_way][idx][{off, 5'd0} +: 32] <= din;
  end

  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache.sv
`default_nettype none
// =============================================================================
// Module   : tb_assoc_cache
// Purpose  : Self-checking bench for assoc_cache (adapts to ASSOC_CACHE_WB_EN).
// Revision : 1.0 - initial release
// =============================================================================
module tb_assoc_cache;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  addr = '0, din = '0, dout;
  logic         re = 1'b0, we = 1'b0, complete;
  logic         mem_re, mem_we, mem_complete = 1'b0;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata = '0;
  logic [3:0]   mem_wmask;

  always #5 clk = ~clk;

  assoc_cache #(.SETS(32), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .din(din),
    .dout(dout), .complete(complete), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_complete(mem_complete)
  );

  typedef struct { logic w; logic [27:0] a; logic [127:0] d; logic [3:0] m; } txn_t;

  int           n_checks = 0, n_pass = 0;
  int           mem_lat = 0, mem_cnt = 0, cyc;
  bit           mem_hold = 1'b0, both_seen = 1'b0;
  logic [127:0] mem [bit [27:0]];
  logic [31:0]  ref_w [bit [29:0]];
  logic [31:0]  exp_q [$];
  txn_t         log_q [$];
  txn_t         t;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] base_line(input logic [27:0] a);
    logic [127:0] l;
    if (a == 28'h4) return {32'd4, 32'd3, 32'd2, 32'd1};
    for (int i = 0; i < 4; i++) l[32*i +: 32] = {a, 4'(i + 1)};
    return l;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [127:0] l;
    if (ref_w.exists(a[31:2])) return ref_w[a[31:2]];
    l = base_line(a[31:4]);
    return l[{a[3:2], 5'd0} +: 32];
  endfunction

  // Block memory: completes after mem_lat counted cycles, one-cycle pulse.
  always @(negedge clk) begin : p_mem
    logic [127:0] line;
    if (mem_re && mem_we) both_seen = 1'b1;
    if (rst) begin
      mem_complete = 1'b0;
      mem_cnt      = 0;
    end else if (mem_complete) begin
      mem_complete = 1'b0;
      mem_cnt      = 0;
    end else if ((mem_re || mem_we) && !mem_hold) begin
      if (mem_cnt >= mem_lat) begin
        line = mem.exists(mem_addr) ? mem[mem_addr] : base_line(mem_addr);
        if (mem_we) begin
          for (int i = 0; i < 4; i++)
            if (mem_wmask[i]) line[32*i +: 32] = mem_wdata[32*i +: 32];
          mem[mem_addr] = line;
        end else begin
          mem_rdata = line;
        end
        log_q.push_back('{mem_we, mem_addr, mem_wdata, mem_wmask});
        mem_complete = 1'b1;
      end else begin
        mem_cnt++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; din = '0;
    mem.delete(); ref_w.delete(); log_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one CPU request and hold it until complete; reads go through the scoreboard.
  task automatic cpu_op(input logic [31:0] a, input logic r, input logic w,
                        input logic [31:0] d, output int n);
    bit done = 1'b0;
    addr = a; re = r; we = w; din = d;
    if (w) ref_w[a[31:2]] = d;
    else   exp_q.push_back(ref_rd(a));
    n = 0;
    while (!done) begin
      #1;
      if (complete) begin
        if (!w) check_val("rd_data", dout, exp_q.pop_front());
        done = 1'b1;
      end else if (n >= 200) begin
        check_val("op_timeout", complete, 1'b1);
        if (!w) void'(exp_q.pop_front());
        done = 1'b1;
      end else begin
        @(posedge clk);
        n++;
      end
    end
    @(posedge clk);
    #1 re = 1'b0; we = 1'b0;
  endtask

  task automatic pop_log(output txn_t x);
    check_val("log_present", log_q.size() > 0, 1'b1);
    if (log_q.size() > 0) x = log_q.pop_front();
    else x = '{1'bx, 'x, 'x, 'x};
  endtask

  initial begin
    do_reset();
    #1;
    check_val("rst_mem_re", mem_re, 1'b0);
    check_val("rst_mem_we", mem_we, 1'b0);
    check_val("rst_wmask", mem_wmask, 4'h0);
    check_val("rst_mem_addr", mem_addr, 28'h0);
    check_val("rst_wdata", mem_wdata, 128'h0);
    check_val("idle_complete", complete, 1'b1);
    check_val("rst_dout", dout, 32'h0);

    // Clean miss then same-line hit
    mem_lat = 0;
    cpu_op(32'h40, 1, 0, 0, cyc);
    check_val("miss_lat_min", cyc, 2);
    pop_log(t);
    check_val("fill_is_read", t.w, 1'b0);
    check_val("fill_addr", t.a, 28'h4);
    cpu_op(32'h44, 1, 0, 0, cyc);
    check_val("hit_lat", cyc, 0);

    // Three fills into set 0: 0x000 is evicted, 0x200 survives
    do_reset();
    mem_lat = 2;
    cpu_op(32'h000, 1, 0, 0, cyc); check_val("miss_lat_000", cyc, 4);
    cpu_op(32'h200, 1, 0, 0, cyc); check_val("miss_lat_200", cyc, 4);
    cpu_op(32'h400, 1, 0, 0, cyc); check_val("miss_lat_400", cyc, 4);
    cpu_op(32'h204, 1, 0, 0, cyc); check_val("hit_200_kept", cyc, 0);
    cpu_op(32'h008, 1, 0, 0, cyc); check_val("miss_000_evicted", cyc, 4);

    // Dirty eviction ordering (write-back) / write-through traffic
    do_reset();
    mem_lat = 1;
    cpu_op(32'h000, 0, 1, 32'hDEADBEEF, cyc);
    cpu_op(32'h200, 1, 0, 0, cyc);
    cpu_op(32'h400, 1, 0, 0, cyc);
`ifdef ASSOC_CACHE_WB_EN
    void'(log_q.pop_front());
    void'(log_q.pop_front());
    pop_log(t);
    check_val("wb_is_write", t.w, 1'b1);
    check_val("wb_addr", t.a, 28'h0);
    check_val("wb_data", t.d[31:0], 32'hDEADBEEF);
    check_val("wb_mask", t.m, 4'hF);
    pop_log(t);
    check_val("wb_then_fill", t.w, 1'b0);
    check_val("wb_fill_addr", t.a, 28'h40);
`else
    pop_log(t);
    check_val("wt_is_write", t.w, 1'b1);
    check_val("wt_addr", t.a, 28'h0);
    check_val("wt_data", t.d, {4{32'hDEADBEEF}});
    check_val("wt_mask", t.m, 4'b0001);
    pop_log(t);
    check_val("wt_no_alloc", t.a, 28'h20);
`endif
    cpu_op(32'h000, 1, 0, 0, cyc);

    // Reset while FILL is outstanding
    do_reset();
    mem_lat  = 0;
    mem_hold = 1'b1;
    addr = 32'h80; re = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("fill_pending_re", mem_re, 1'b1);
    check_val("fill_pending_addr", mem_addr, 28'h8);
    rst = 1'b1;
    #1;
    check_val("async_rst_mem_re", mem_re, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0; re = 1'b0; mem_hold = 1'b0;
    cpu_op(32'h80, 1, 0, 0, cyc);
    check_val("miss_after_rst", cyc, 2);

    // re and we together on a hit act as a write
    do_reset();
    cpu_op(32'h100, 1, 0, 0, cyc);
    cpu_op(32'h100, 1, 1, 32'h5, cyc);
`ifdef ASSOC_CACHE_WB_EN
    check_val("rw_hit_lat", cyc, 0);
`else
    check_val("rw_wt_lat", cyc, 2);
`endif
    cpu_op(32'h100, 1, 0, 0, cyc);
    check_val("rw_read_hit", cyc, 0);

    // Write miss to 0x48: allocation depends on the policy
    do_reset();
    cpu_op(32'h48, 0, 1, 32'h7, cyc);
    pop_log(t);
`ifdef ASSOC_CACHE_WB_EN
    check_val("wmiss_alloc_fill", t.w, 1'b0);
    cpu_op(32'h48, 1, 0, 0, cyc);
    check_val("wmiss_then_hit", cyc, 0);
`else
    check_val("wmiss_wt_write", t.w, 1'b1);
    check_val("wmiss_wt_mask", t.m, 4'b0100);
    check_val("wmiss_wt_addr", t.a, 28'h4);
    cpu_op(32'h48, 1, 0, 0, cyc);
    check_val("wmiss_no_alloc", cyc, 2);
`endif

    check_val("re_we_exclusive", both_seen, 1'b0);
    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/assoc_cache.md
# assoc_cache

- Parametrised N-way set-associative data cache with an internal miss FSM.
- Generalises the direct-mapped 64×4-word cache to configurable sets and ways, with write-back/write-allocate, dirty tracking and per-set round-robin replacement.
- Sits between the MIPS pipeline memory stage and a 128-bit block-wide data RAM port.
- Keeps the existing CPU-side `addr/re/we/din/dout/complete` contract, so it drops into the same slot.

## Interface
Parameters:
- `SETS`, 32: sets; power of two, ≥2. `IDX_W = log2(SETS)`.
- `WAYS`, 2: ways per set; one of 1, 2, 4. `WAY_W = max(1, log2(WAYS))`.
- `TAG_W`, `30-2-IDX_W`: derived, not overridable.

Ports:
- `clk` in 1: single clock. Every state change is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `addr` in 32: CPU byte address.
  - `[1:0]` ignored.
  - `[3:2]` word offset.
  - `[4+IDX_W-1:4]` index.
  - Upper bits are the tag.
- `re` in 1: read request.
- `we` in 1: write request. Has priority when `re` is also high.
- `din` in 32: write data.
- `dout` out 32: read data. Valid when `re & complete`.
- `complete` out 1: request finished this cycle.
- `mem_re` out 1: block read request.
- `mem_we` out 1: block write request.
- `mem_addr` out 28: block address, `addr[31:4]` or victim tag+index.
- `mem_wdata` out 128: write data. Word `i` is at `[32i+31:32i]`.
- `mem_wmask` out 4: word write enables.
- `mem_rdata` in 128: fill data. Valid when `mem_complete` is high.
- `mem_complete` in 1: one-cycle pulse that ends the outstanding memory request.

## Operation
- Per way and set, the cache holds: `valid`, `dirty`, tag, and 128-bit data. Each set also holds a `WAY_W`-bit round-robin pointer `rr`.
- Lookup is combinational. `hit` = any way with valid and tag equal.
- FSM states: `IDLE`, `WB`, `FILL`, `WT`. `WT` exists only without the configuration macro.
- **IDLE, no request:** `complete=1`.
- **IDLE, read hit:** `complete=1`; `dout` = hit way word `[offset]`.
- **IDLE, write hit:** `complete=1`. At the edge, write the word into the hit way and set `dirty`.
- **IDLE, miss:**
  - Choose the victim: lowest-index invalid way, else `rr[index]`.
  - If the victim is valid and dirty, go to `WB`; otherwise go to `FILL`. `complete=0`.
- **WB:**
  - Drive `mem_we=1`, `mem_addr={victim tag,index}`, `mem_wdata`=victim data, `mem_wmask=4'b1111`.
  - On `mem_complete`, clear victim `dirty` and go to `FILL`.
- **FILL:**
  - Drive `mem_re=1`, `mem_addr=addr[31:4]`.
  - On `mem_complete`, write `mem_rdata` into the victim: tag installed, `valid=1`, `dirty=0`.
  - Advance `rr[index]` modulo `WAYS`. Go to `IDLE`.
  - The retried request then hits.
- Memory outputs are registered. They stay stable from assertion until the cycle `mem_complete` is sampled high, then drop the next cycle.
- `mem_re` and `mem_we` are never both high.
- `mem_complete` while in `IDLE` is ignored.
- CPU holds `addr/din/re/we` until `complete`.
  - If the request is withdrawn mid-miss, the outstanding memory transaction still finishes and installs the line. The FSM then returns to `IDLE`.
- **Reset:**
  - Clears all `valid`, `dirty` and `rr`; FSM goes to `IDLE`.
  - `mem_re`, `mem_we`, `mem_wmask`, `mem_addr` and `mem_wdata` go to 0 immediately.
  - `dout` reads 0 while `valid` is clear.
  - Dirty data is discarded. A reset mid-`WB`/`FILL` aborts without any write to the arrays.

## Timing
- Hit: 0-cycle latency. `complete` is high in the same cycle as the request.
- Clean miss:
  - Miss seen in cycle 0; `mem_re` is high from cycle 1.
  - `mem_complete` arrives in cycle k; `complete=1` in cycle k+1.
- Dirty miss: adds the `WB` phase before `FILL`, with `mem_re` asserted the cycle after `mem_complete` ends `WB`.
- Minimum miss: 3 cycles when memory completes in the first request cycle.

## Configuration
- `ASSOC_CACHE_WB_EN` defined: write-back/write-allocate as above. `mem_wmask` is always `4'b1111`.
- `ASSOC_CACHE_WB_EN` undefined: write-through/no-write-allocate.
  - `dirty` and `WB` are removed.
  - Every write enters `WT`: `mem_we=1`, `mem_addr=addr[31:4]`, `din` replicated in all four words, `mem_wmask` one-hot at `offset`.
  - On a write hit, the cache word is also updated at `WT` entry.
  - `complete=1` in the cycle after `mem_complete`.
  - A write miss does not allocate.
  - Read misses always go straight to `FILL`.

## Test plan
Defaults `SETS=32`, `WAYS=2`, `ASSOC_CACHE_WB_EN` defined.
- Read `0x40` after reset → `mem_re=1`, `mem_addr=0x0000004`. Return `mem_rdata` words {4,3,2,1}. Retry `complete`, `dout=1`; then read `0x44` → same-cycle `complete`, `dout=2`.
- Fill `0x000`, then `0x200`, then `0x400` (all set 0) → victims way0, way1, way0; `0x000` evicted; a read of `0x200` still hits.
- Write `0xDEADBEEF` to `0x000`, then miss on `0x200` and `0x400` → `mem_we=1`, `mem_addr=0x0`, `mem_wdata[31:0]=0xDEADBEEF` before `mem_re` with `mem_addr=0x40`.
- `rst` pulsed while in `FILL`, `mem_complete` never given → `mem_re` drops asynchronously; a following read of the same address misses again.
- `re=we=1` on a hit, `din=0x5` → treated as write; a subsequent read returns `0x5`.
- Macro undefined: write `0x7` to `0x48` (miss) → `mem_we`, `mem_wmask=4'b0100`, no allocate; a later read of `0x48` misses.
